// File: rtl/register_tx_sequencer.sv
// register_tx_sequencer: front end for the universal 8-bit register.
// It accepts one word over a valid/ready handshake, parallel-loads it into
// the register, then shifts it out one bit every BIT_CYCLES clocks. Each bit
// is taken from the register's output end, and the register is cleared when
// the word has been sent.
//
// Handshake: a word transfers on a rising clk edge where in_valid=1 and
// in_ready=1. in_ready is high only in IDLE, and it depends on state alone.
// When in_ready=0, in_valid is ignored and the source must hold its word.
module register_tx_sequencer #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             sync_nreset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  output logic [2:0]       reg_ctrl,
  output logic [WIDTH-1:0] reg_parallel_data,
  output logic             reg_serial_data,
  input  logic [WIDTH-1:0] reg_data_output,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int HOLD_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(BIT_CYCLES - 1);

  // Register opcodes
  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_CLR   = 3'd1;
  localparam logic [2:0] OP_PLOAD = 3'd2;
  localparam logic [2:0] OP_SLL   = 3'd5;
  localparam logic [2:0] OP_SRL   = 3'd6;

  // FSM states
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [WIDTH-1:0]  word_q, word_d;
  logic              msb_q, msb_d;

  // Next state: capture the word in IDLE, then step through the bit and hold counters in SHIFT
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    hold_cnt_d = hold_cnt_q;
    word_d     = word_q;
    msb_d      = msb_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          word_d  = in_data;
          msb_d   = in_msb_first;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        bit_cnt_d  = '0;
        hold_cnt_d = '0;
        state_d    = S_SHIFT;
      end
      S_SHIFT: begin
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            // The counter stops at its terminal value; LOAD re-zeroes it.
            state_d = S_CLEAR;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!sync_nreset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      hold_cnt_q <= '0;
      word_q     <= '0;
      msb_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      word_q     <= word_d;
      msb_q      <= msb_d;
    end
  end

  // Moore output decode from state and counters (never from in_valid)
  always_comb begin
    in_ready     = 1'b0;
    reg_ctrl     = OP_NONE;
    serial_valid = 1'b0;
    serial_out   = 1'b0;
    done         = 1'b0;
    case (state_q)
      S_IDLE:  in_ready = 1'b1;
      S_LOAD:  reg_ctrl = OP_PLOAD;
      S_SHIFT: begin
        serial_valid = 1'b1;
        serial_out   = msb_q ? reg_data_output[WIDTH-1] : reg_data_output[0];
        if (hold_cnt_q == HOLD_LAST) reg_ctrl = msb_q ? OP_SLL : OP_SRL;
      end
      S_CLEAR: begin
        reg_ctrl = OP_CLR;
        done     = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // The captured word stays on the parallel bus; only reg_ctrl qualifies it.
  assign reg_parallel_data = word_q;
  assign reg_serial_data   = 1'b0;
  assign dbg_state         = state_q;

endmodule

// File: doc/register_tx_sequencer.md
Name: register_tx_sequencer

Overview:
- Upstream control stage for the 8-bit universal `register` block (ctrl opcodes NONE/CLR/PARALLEL_LOAD/SERIAL_MSB_LOAD/SERIAL_LSB_LOAD/SHIFT_LOGICAL_LEFT/SHIFT_LOGICAL_RIGHT = 0..6).
- Accepts a parallel word over a valid/ready handshake and drives the register's ctrl and parallel inputs to load the word.
- Shifts the word out MSB-first or LSB-first, one bit per BIT_CYCLES clocks.
- Presents each bit on a serial output, then clears the register.

Parameters:
- WIDTH, 8, data width; must match the register's WIDTH.
- BIT_CYCLES, 1, clocks each serial bit is held (≥1).

Ports:
- clk  input  1  clock, rising edge.
- sync_nreset  input  1  synchronous active-low reset.
- in_valid  input  1  word available.
- in_ready  output  1  sequencer can accept a word.
- in_data  input  WIDTH  word to transmit.
- in_msb_first  input  1  1: MSB first (shift left); 0: LSB first (shift right); sampled with in_data.
- reg_ctrl  output  3  opcode to register ctrl.
- reg_parallel_data  output  WIDTH  to register parallel_data_input.
- reg_serial_data  output  1  to register serial_data_input; constant 0.
- reg_data_output  input  WIDTH  from register data_output.
- serial_out  output  1  current transmitted bit.
- serial_valid  output  1  serial_out holds a valid bit.
- done  output  1  one-cycle pulse at end of word.

Behaviour:
- All state changes on rising clk; sync_nreset sampled only at the edge.
- Reset (any state, including mid-word):
  - state=IDLE, bit and hold counters 0, captured word 0, direction=MSB.
  - Outputs: reg_ctrl=NONE, reg_parallel_data=0, in_ready=1, serial_valid=0, serial_out=0, done=0.
  - The register itself is not cleared by this block on reset.
- FSM is Moore: outputs decode from state/counters only, never combinationally from in_valid.
- IDLE:
  - in_ready=1, reg_ctrl=NONE.
  - On in_valid=1 at an edge: capture in_data and in_msb_first, go to LOAD.
- LOAD (1 cycle):
  - in_ready=0, reg_ctrl=PARALLEL_LOAD, reg_parallel_data=captured word.
  - Go to SHIFT with bit_cnt=0 and hold_cnt=0.
- SHIFT:
  - serial_valid=1.
  - serial_out = reg_data_output[WIDTH-1] if MSB-first, else reg_data_output[0].
  - reg_ctrl=NONE while hold_cnt<BIT_CYCLES-1.
  - When hold_cnt=BIT_CYCLES-1: reg_ctrl=SHIFT_LOGICAL_LEFT (MSB-first) or SHIFT_LOGICAL_RIGHT (LSB-first), hold_cnt wraps to 0, bit_cnt increments.
  - When bit_cnt=WIDTH-1 and hold_cnt=BIT_CYCLES-1: go to CLEAR.
- CLEAR (1 cycle):
  - reg_ctrl=CLR, done=1, serial_valid=0, in_ready=0.
  - Go to IDLE.
- Latency and throughput:
  - Handshake edge → LOAD next cycle; first bit valid 2 cycles after the handshake edge.
  - Busy window = 1 + WIDTH·BIT_CYCLES + 1 cycles.
  - Back-to-back words: next handshake earliest in the first IDLE cycle after CLEAR.
- Counters:
  - bit_cnt width clog2(WIDTH).
  - hold_cnt width clog2(BIT_CYCLES), minimum 1 bit.
  - No wrap beyond terminal values.
- in_valid while in_ready=0 is ignored; the word is not captured and the source must hold it.
- in_data/in_msb_first changes after capture have no effect on the word in flight.
- reg_parallel_data holds the captured word until the next capture; only reg_ctrl qualifies it.

Test Plan:
- Reset/idle:
  - Stimulus: sync_nreset=0 for 2 cycles, then 1, no valid.
  - Required: reg_ctrl=0, in_ready=1, serial_valid=0, done=0 on every cycle.
- MSB-first, BIT_CYCLES=1, in_data=8'b1010_0011, bench instantiates `register`:
  - reg_ctrl sequence is 2, then 5×8, then 1.
  - serial_out = 1,0,1,0,0,0,1,1.
  - done pulses exactly once.
  - Register reads 0 after CLR.
- LSB-first, same word:
  - reg_ctrl uses 6 for shifts.
  - serial_out = 1,1,0,0,0,1,0,1.
- BIT_CYCLES=3, MSB-first, 8'hF0:
  - Each bit held 3 cycles; shift opcode only on every 3rd SHIFT cycle.
  - serial_valid high for 24 cycles; busy window 26 cycles.
- Handshake corner:
  - Stimulus: in_valid held high continuously with data 8'h55 then 8'hAA (changed mid-transmission).
  - Required: first word transmitted intact as 8'h55; in_ready=0 throughout busy; 8'hAA is accepted only in the IDLE cycle after CLEAR.
- Reset mid-operation:
  - Stimulus: sync_nreset=0 during bit 4 of a word.
  - Required: next cycle state=IDLE, serial_valid=0, reg_ctrl=0, in_ready=1.
  - A new word afterwards transmits correctly from bit 0.
